// File: rtl/jtpopeye_objdraw.sv
// Object line renderer: fetches one 2bpp pattern row per 4-pixel slot and serialises it
// through three round-robin pixel shifters, merging them so the oldest opaque object wins.
module jtpopeye_objdraw #(
   parameter int ROM_AW = 12
) (
   input  logic              rst_n,
   input  logic              clk,
   input  logic              pxl_cen,
   input  logic [7:0]        H,
   input  logic              HB,
   input  logic [17:0]       DJ,
   output logic              rom_cs,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   input  logic              rom_ok,
   output logic [4:0]        obj_pxl,
   output logic [7:0]        drop_cnt
);
   typedef enum logic [1:0] {IDLE, FETCH, READY} state_t;

   state_t      st;
   logic        slot0, slot3, start, handoff;
   logic [2:0]  ent_pal;
   logic [1:0]  ent_off;
   logic        ent_hflip;
   logic [15:0] ent_pat;

   logic [2:0]  ser_pal   [3];
   logic        ser_hflip [3];
   logic [15:0] ser_pat   [3];
   logic [1:0]  ser_dly   [3];
   logic [3:0]  ser_cnt   [3];
   logic [2:0]  bit_idx   [3];
   logic [1:0]  ser_col   [3];
   logic        ser_emit  [3];
   logic [1:0]  rr;
   logic [1:0]  idx;
   logic        found;
   logic [4:0]  pxl_nx;
   logic        unused_h;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [1:0] ring(input logic [1:0] base, input logic [1:0] k);
      logic [2:0] sum;
      sum = {1'b0, base} + {1'b0, k};
      return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
   endfunction

   assign unused_h = ^H[7:2];
   assign slot0    = pxl_cen && (H[1:0] == 2'b00);
   assign slot3    = pxl_cen && (H[1:0] == 2'b11);
   assign handoff  = (st == READY) && slot0;
   // READY is also a valid start state so that consecutive slots can be back-to-back
   assign start    = slot0 && !HB && (DJ[16:14] != 3'd0) && (st != FETCH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= IDLE;
         rom_cs   <= 1'b0;
         rom_addr <= '0;
         drop_cnt <= '0;
      end else if (start) begin
         st       <= FETCH;
         rom_cs   <= 1'b1;
         rom_addr <= ROM_AW'({DJ[17], DJ[10:4], DJ[3:1], DJ[0]});
      end else begin
         case (st)
            FETCH: begin
               if (rom_ok) begin
                  rom_cs <= 1'b0;
                  st     <= READY;
               end else if (slot3) begin
                  rom_cs   <= 1'b0;
                  drop_cnt <= sat_inc(drop_cnt);
                  st       <= IDLE;
               end
            end
            READY:   if (slot0) st <= IDLE;
            default: st <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         ent_pal   <= DJ[16:14];
         ent_off   <= DJ[13:12];
         ent_hflip <= DJ[11];
      end
      if (st == FETCH && rom_ok) ent_pat <= rom_data;
   end

   // Serialiser bank: current pixel of each shifter, then oldest-first merge
   always_comb begin
      for (int s = 0; s < 3; s++) begin
         bit_idx[s]  = ser_hflip[s] ? 3'(4'd8 - ser_cnt[s]) : 3'(ser_cnt[s] - 4'd1);
         ser_col[s]  = {ser_pat[s][{1'b1, bit_idx[s]}], ser_pat[s][{1'b0, bit_idx[s]}]};
         ser_emit[s] = (ser_cnt[s] != 4'd0) && (ser_dly[s] == 2'd0);
      end
      pxl_nx = 5'd0;
      found  = 1'b0;
      idx    = 2'd0;
      // rr points at the least recently loaded shifter, i.e. the oldest one
      for (int k = 0; k < 3; k++) begin
         idx = ring(rr, 2'(k));
         if (!found && ser_emit[idx] && ser_col[idx] != 2'b00) begin
            pxl_nx = {ser_pal[idx], ser_col[idx]};
            found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr      <= 2'd0;
         obj_pxl <= 5'd0;
         for (int s = 0; s < 3; s++) begin
            ser_cnt[s] <= 4'd0;
            ser_dly[s] <= 2'd0;
         end
      end else if (pxl_cen) begin
         obj_pxl <= HB ? 5'd0 : pxl_nx;
         for (int s = 0; s < 3; s++) begin
            if (handoff && rr == 2'(s)) begin
               ser_cnt[s] <= 4'd8;
               ser_dly[s] <= ent_off;
            end else if (ser_cnt[s] != 4'd0) begin
               if (ser_dly[s] != 2'd0) ser_dly[s] <= ser_dly[s] - 2'd1;
               else                    ser_cnt[s] <= ser_cnt[s] - 4'd1;
            end
         end
         if (handoff) begin
            assert (ser_cnt[rr] == 4'd0);
            rr <= (rr == 2'd2) ? 2'd0 : rr + 2'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int s = 0; s < 3; s++) begin
         if (handoff && rr == 2'(s)) begin
            ser_pal[s]   <= ent_pal;
            ser_hflip[s] <= ent_hflip;
            ser_pat[s]   <= ent_pat;
         end
      end
   end
endmodule

// File: tb/tb_jtpopeye_objdraw.sv
// Bench for jtpopeye_objdraw: directed object entries, a queued ROM responder and a
// per-pixel scoreboard on obj_pxl.
module tb_jtpopeye_objdraw;
   logic        rst_n, clk, pxl_cen, HB, rom_cs, rom_ok;
   logic [7:0]  H, drop_cnt;
   logic [17:0] DJ;
   logic [11:0] rom_addr;
   logic [15:0] rom_data;
   logic [4:0]  obj_pxl;

   jtpopeye_objdraw #(.ROM_AW(12)) dut (
      .rst_n    (rst_n),
      .clk      (clk),
      .pxl_cen  (pxl_cen),
      .H        (H),
      .HB       (HB),
      .DJ       (DJ),
      .rom_cs   (rom_cs),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .rom_ok   (rom_ok),
      .obj_pxl  (obj_pxl),
      .drop_cnt (drop_cnt)
   );

   typedef struct { int t; logic [4:0] v; } exp_t;
   typedef struct { logic [11:0] addr; logic [15:0] data; int lat; bit late_ok; } req_t;

   exp_t       exp_q[$];
   req_t       rom_q[$];
   int         n_vec  = 0;
   int         n_fail = 0;
   int         ptick  = 0;
   int         mon_tick = 0;
   logic [4:0] win [0:31];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [17:0] mk_dj(input logic [7:0] id, input logic [2:0] pal,
                                         input logic [1:0] off, input logic hf,
                                         input logic [2:0] row, input logic lsb);
      return {id[7], pal, off, hf, id[6:0], row, lsb};
   endfunction

   function automatic logic [11:0] mk_addr(input logic [7:0] id, input logic [2:0] row, input logic lsb);
      return {id, row, lsb};
   endfunction

   task automatic win_clear();
      for (int k = 0; k < 32; k++) win[k] = 5'd0;
   endtask

   // Paint one object into the expected window; earlier calls are older objects and win.
   task automatic paint(input int h, input logic [2:0] pal, input int off, input bit hf,
                        input logic [15:0] pat);
      for (int j = 0; j < 8; j++) begin
         int i;
         int t;
         logic [1:0] c;
         i = hf ? j : 7 - j;
         c = {pat[8+i], pat[i]};
         t = h + 1 + off + j;
         if (c != 2'b00 && win[t] == 5'd0) win[t] = {pal, c};
      end
   endtask

   task automatic push_window(input int t0, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back('{t0 + k, win[k]});
   endtask

   task automatic pclk();
      pxl_cen = 1'b1;
      @(posedge clk); #1;
      pxl_cen = 1'b0;
      H = H + 8'd1;
      ptick++;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic align();
      while (H[1:0] != 2'b00) pclk();
   endtask

   // ROM responder: pops the expected request on each new rom_cs and answers after lat clocks
   initial begin
      req_t cur;
      bit   busy;
      int   cnt;
      rom_ok = 1'b0; rom_data = 16'h0; busy = 1'b0; cnt = 0;
      cur = '{12'h0, 16'h0, 1000, 1'b0};
      forever begin
         @(posedge clk); #1;
         if (!busy && rom_cs) begin
            if (rom_q.size() == 0) begin
               check("rom_cs_unexpected", rom_cs, 1'b0);
               cur = '{12'h0, 16'h0, 1000, 1'b0};
            end else begin
               cur = rom_q.pop_front();
               check("rom_addr", rom_addr, cur.addr);
            end
            busy = 1'b1;
            cnt  = 0;
         end
         if (busy) begin
            cnt++;
            if (cnt == cur.lat) begin
               rom_ok   = 1'b1;
               rom_data = cur.data;
            end else if (rom_ok && !rom_cs) begin
               rom_ok = 1'b0;
               busy   = 1'b0;
            end else if (!rom_ok && !rom_cs && !cur.late_ok) begin
               busy = 1'b0;
            end
         end
      end
   end

   // Pixel monitor: one scoreboard entry per pxl_cen tick
   initial begin
      exp_t e;
      int   t;
      forever begin
         @(posedge clk);
         if (pxl_cen) begin
            t = mon_tick;
            mon_tick++;
            #2;
            while (exp_q.size() > 0 && exp_q[0].t <= t) begin
               e = exp_q.pop_front();
               n_vec++;
               if (e.t < t) begin
                  n_fail++;
                  $display("FAIL obj_pxl tick %0d: not checked (now tick %0d), expected 0x%0h", e.t, t, e.v);
               end else if (obj_pxl !== e.v) begin
                  n_fail++;
                  $display("FAIL obj_pxl tick %0d: got 0x%0h, expected 0x%0h", t, obj_pxl, e.v);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      logic [17:0] ea, eb;
      rst_n = 1'b0; pxl_cen = 1'b0; H = 8'd0; HB = 1'b0; DJ = 18'd0;
      repeat (3) @(posedge clk); #1;
      check("rst_rom_cs", rom_cs, 1'b0);
      check("rst_rom_addr", rom_addr, 12'h000);
      check("rst_obj_pxl", obj_pxl, 5'd0);
      check("rst_drop_cnt", drop_cnt, 8'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic entry: ID 0x12 row 3, colour 1 on all pixels, palette 5
      align(); t0 = ptick; win_clear();
      paint(4, 3'd5, 0, 1'b0, 16'h00FF); push_window(t0, 24);
      rom_q.push_back('{12'h126, 16'h00FF, 2, 1'b0});
      DJ = mk_dj(8'h12, 3'd5, 2'd0, 1'b0, 3'd3, 1'b0); pclk(); DJ = 18'd0;
      repeat (23) pclk();

      // Same entry flipped: the single opaque pixel comes out first
      align(); t0 = ptick; win_clear();
      paint(4, 3'd5, 0, 1'b1, 16'h0001); push_window(t0, 24);
      rom_q.push_back('{12'h126, 16'h0001, 2, 1'b0});
      DJ = mk_dj(8'h12, 3'd5, 2'd0, 1'b1, 3'd3, 1'b0); pclk(); DJ = 18'd0;
      repeat (23) pclk();

      // Offset 3 then offset 0 in the next slot: overlap shows the older palette 2
      align(); t0 = ptick; win_clear();
      paint(4, 3'd2, 3, 1'b0, 16'hFFFF); paint(8, 3'd4, 0, 1'b0, 16'hFFFF); push_window(t0, 24);
      rom_q.push_back('{mk_addr(8'h21, 3'd1, 1'b1), 16'hFFFF, 2, 1'b0});
      rom_q.push_back('{mk_addr(8'hA5, 3'd6, 1'b0), 16'hFFFF, 2, 1'b0});
      ea = mk_dj(8'h21, 3'd2, 2'd3, 1'b0, 3'd1, 1'b1);
      eb = mk_dj(8'hA5, 3'd4, 2'd0, 1'b0, 3'd6, 1'b0);
      DJ = ea; pclk(); DJ = 18'd0;
      repeat (3) pclk();
      DJ = eb; pclk(); DJ = 18'd0;
      repeat (19) pclk();

      // Late ROM answer: first entry dropped, next slot's entry drawn normally
      align(); t0 = ptick; win_clear();
      paint(8, 3'd6, 1, 1'b1, 16'hA5C3); push_window(t0, 24);
      rom_q.push_back('{mk_addr(8'h33, 3'd2, 1'b0), 16'hFFFF, 200, 1'b0});
      rom_q.push_back('{mk_addr(8'h44, 3'd5, 1'b1), 16'hA5C3, 3, 1'b0});
      DJ = mk_dj(8'h33, 3'd3, 2'd0, 1'b0, 3'd2, 1'b0); pclk(); DJ = 18'd0;
      pclk(); pclk();
      check("drop_pending_rom_cs", rom_cs, 1'b1);
      pclk();
      check("drop_rom_cs", rom_cs, 1'b0);
      check("drop_cnt", drop_cnt, 8'd1);
      DJ = mk_dj(8'h44, 3'd6, 2'd1, 1'b1, 3'd5, 1'b1); pclk(); DJ = 18'd0;
      repeat (19) pclk();
      check("drop_cnt_after", drop_cnt, 8'd1);

      // Blanking in the middle of an object hides those pixels only
      align(); t0 = ptick; win_clear();
      paint(4, 3'd5, 0, 1'b0, 16'hFFFF);
      win[5] = 5'd0; win[6] = 5'd0; win[7] = 5'd0;
      push_window(t0, 24);
      rom_q.push_back('{mk_addr(8'h5A, 3'd4, 1'b1), 16'hFFFF, 2, 1'b0});
      DJ = mk_dj(8'h5A, 3'd5, 2'd0, 1'b0, 3'd4, 1'b1); pclk(); DJ = 18'd0;
      repeat (4) pclk();
      HB = 1'b1; repeat (3) pclk(); HB = 1'b0;
      repeat (16) pclk();

      // Entries during HB or with palette 0 never fetch
      align(); t0 = ptick; win_clear(); push_window(t0, 16);
      for (int k = 0; k < 16; k++) begin
         HB = (k < 4);
         DJ = (k < 4) ? mk_dj(8'h77, 3'd7, 2'd0, 1'b0, 3'd1, 1'b0)
                      : mk_dj(8'hFF, 3'd0, 2'd3, 1'b1, 3'd7, 1'b1);
         pclk();
         check("no_fetch_rom_cs", rom_cs, 1'b0);
      end
      HB = 1'b0; DJ = 18'd0;

      // Reset in the middle of a fetch, ROM answers afterwards
      align(); t0 = ptick; win_clear(); push_window(t0, 16);
      rom_q.push_back('{mk_addr(8'h66, 3'd0, 1'b1), 16'hFFFF, 6, 1'b1});
      DJ = mk_dj(8'h66, 3'd1, 2'd0, 1'b0, 3'd0, 1'b1);
      pxl_cen = 1'b1;
      @(posedge clk); #1;
      pxl_cen = 1'b0; H = H + 8'd1; ptick++; DJ = 18'd0;
      check("rstf_rom_cs_before", rom_cs, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b0; #1;
      check("rstf_rom_cs", rom_cs, 1'b0);
      check("rstf_rom_addr", rom_addr, 12'h000);
      check("rstf_obj_pxl", obj_pxl, 5'd0);
      check("rstf_drop_cnt", drop_cnt, 8'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;
      for (int k = 0; k < 15; k++) begin
         pclk();
         check("rstf_late_rom_cs", rom_cs, 1'b0);
      end

      repeat (4) pclk();
      check("scoreboard_drained", exp_q.size(), 0);
      check("rom_requests_drained", rom_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
